// File: rtl/cpu_io_channel_bridge.sv
// cpu_io_channel_bridge
// Operand path: CPU -> FIFO -> fabric. Result path: fabric strobe -> FIFO -> CPU.
// ConfigBits[0] bypasses the operand FIFO, ConfigBits[1] bypasses the result
// FIFO; both bypasses are purely combinational and freeze the FIFO state.
// Optional feature macro: CPU_IO_ERR_FLAGS_EN enables the sticky err_ovf /
// err_unf flags. Without it both flags are constant 0 and no registers exist.
module cpu_io_channel_bridge #(
  parameter int NUM_OPS = 2,
  parameter int NUM_RES = 3,
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [1:0]                 ConfigBits,
  input  logic [NUM_OPS*WIDTH-1:0]   cpu_op_data,
  input  logic                       cpu_op_valid,
  output logic                       cpu_op_ready,
  output logic [NUM_OPS*WIDTH-1:0]   fab_op_data,
  output logic                       fab_op_valid,
  input  logic                       fab_op_ack,
  input  logic [NUM_RES*WIDTH-1:0]   fab_res_data,
  input  logic                       fab_res_strobe,
  output logic [NUM_RES*WIDTH-1:0]   cpu_res_data,
  output logic                       cpu_res_valid,
  input  logic                       cpu_res_ready,
  output logic [AW:0]                op_level,
  output logic [AW:0]                res_level,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int OW = NUM_OPS * WIDTH;
  localparam int RW = NUM_RES * WIDTH;

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  // Static configuration decode
  logic op_byp;
  logic res_byp;
  assign op_byp  = ConfigBits[0];
  assign res_byp = ConfigBits[1];

  // ---------------------------------------------------------------------------
  // Ready enable: cpu_op_ready stays low in reset and rises on the first edge
  // after resetn deasserts (the FIFO itself is already empty at that point).
  // ---------------------------------------------------------------------------
  logic ready_en;

  // Arm cpu_op_ready one clock edge after reset release
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) ready_en <= 1'b0;
    else         ready_en <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------------
  logic [OW-1:0] op_mem [DEPTH];
  logic [AW-1:0] op_wr_ptr;
  logic [AW-1:0] op_rd_ptr;
  logic [AW:0]   op_cnt;
  logic          op_full;
  logic          op_empty;
  logic          op_push;
  logic          op_pop;

  assign op_full  = (op_cnt == FULL_LVL);
  assign op_empty = (op_cnt == '0);
  // Readiness comes from occupancy only, so a full FIFO refuses a write even
  // when the fabric pops in the same cycle.
  assign op_push  = !op_byp && cpu_op_valid && ready_en && !op_full;
  // An ack against an empty FIFO is ignored.
  assign op_pop   = !op_byp && fab_op_ack && !op_empty;

  // Operand pointers and occupancy; pointers wrap modulo DEPTH
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      op_wr_ptr <= '0;
      op_rd_ptr <= '0;
      op_cnt    <= '0;
    end else begin
      if (op_push) op_wr_ptr <= op_wr_ptr + ONE_PTR;
      if (op_pop)  op_rd_ptr <= op_rd_ptr + ONE_PTR;
      case ({op_push, op_pop})
        2'b10:   op_cnt <= op_cnt + ONE_LVL;
        2'b01:   op_cnt <= op_cnt - ONE_LVL;
        default: op_cnt <= op_cnt;
      endcase
    end
  end

  // Operand storage write
  // NOTE: data storage has no reset; it is only observable through a valid
  // head, and the reset of the pointers/levels is what discards contents.
  always_ff @(posedge UserCLK) begin
    if (op_push) op_mem[op_wr_ptr] <= cpu_op_data;
  end

  // Operand-side outputs, FIFO or combinational bypass
  // NOTE: every always_comb output gets a default first so no latch can form.
  always_comb begin
    fab_op_data  = '0;
    fab_op_valid = 1'b0;
    cpu_op_ready = 1'b0;
    op_level     = '0;
    if (op_byp) begin
      fab_op_data  = cpu_op_data;
      fab_op_valid = cpu_op_valid;
      cpu_op_ready = ready_en && fab_op_ack;
    end else begin
      fab_op_valid = !op_empty;
      if (!op_empty) fab_op_data = op_mem[op_rd_ptr];
      cpu_op_ready = ready_en && !op_full;
      op_level     = op_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [RW-1:0] res_mem [DEPTH];
  logic [AW-1:0] res_wr_ptr;
  logic [AW-1:0] res_rd_ptr;
  logic [AW:0]   res_cnt;
  logic          res_full;
  logic          res_empty;
  logic          res_push;
  logic          res_pop;

  assign res_full  = (res_cnt == FULL_LVL);
  assign res_empty = (res_cnt == '0);
  assign res_pop   = !res_byp && cpu_res_ready && !res_empty;
  // A full FIFO still captures when the head leaves in the same cycle; the
  // freed slot is the one the write pointer already addresses.
  assign res_push  = !res_byp && fab_res_strobe && (!res_full || res_pop);

  // Result pointers and occupancy; pointers wrap modulo DEPTH
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_cnt    <= '0;
    end else begin
      if (res_push) res_wr_ptr <= res_wr_ptr + ONE_PTR;
      if (res_pop)  res_rd_ptr <= res_rd_ptr + ONE_PTR;
      case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + ONE_LVL;
        2'b01:   res_cnt <= res_cnt - ONE_LVL;
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  // Result storage write
  always_ff @(posedge UserCLK) begin
    if (res_push) res_mem[res_wr_ptr] <= fab_res_data;
  end

  // Result-side outputs, FIFO or combinational bypass
  always_comb begin
    cpu_res_data  = '0;
    cpu_res_valid = 1'b0;
    res_level     = '0;
    if (res_byp) begin
      cpu_res_data  = fab_res_data;
      cpu_res_valid = fab_res_strobe;
    end else begin
      cpu_res_valid = !res_empty;
      if (!res_empty) cpu_res_data = res_mem[res_rd_ptr];
      res_level     = res_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional sticky error flags
  // ---------------------------------------------------------------------------
`ifdef CPU_IO_ERR_FLAGS_EN
  logic res_drop;
  logic op_underflow;
  logic ovf_q;
  logic unf_q;

  assign res_drop     = !res_byp && fab_res_strobe && res_full && !res_pop;
  assign op_underflow = !op_byp && fab_op_ack && op_empty;

  // Sticky flags, cleared only by reset
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (res_drop)     ovf_q <= 1'b1;
      if (op_underflow) unf_q <= 1'b1;
    end
  end

  assign err_ovf = ovf_q;
  assign err_unf = unf_q;
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_io_channel_bridge.sv
// Self-checking bench for cpu_io_channel_bridge: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_cpu_io_channel_bridge;

  localparam int NUM_OPS = 2;
  localparam int NUM_RES = 3;
  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;
  localparam int OW      = NUM_OPS * WIDTH;
  localparam int RW      = NUM_RES * WIDTH;

`ifdef CPU_IO_ERR_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic          UserCLK = 1'b0;
  logic          resetn;
  logic [1:0]    ConfigBits;
  logic [OW-1:0] cpu_op_data;
  logic          cpu_op_valid;
  logic          cpu_op_ready;
  logic [OW-1:0] fab_op_data;
  logic          fab_op_valid;
  logic          fab_op_ack;
  logic [RW-1:0] fab_res_data;
  logic          fab_res_strobe;
  logic [RW-1:0] cpu_res_data;
  logic          cpu_res_valid;
  logic          cpu_res_ready;
  logic [AW:0]   op_level;
  logic [AW:0]   res_level;
  logic          err_ovf;
  logic          err_unf;

  always #5 UserCLK = ~UserCLK;

  cpu_io_channel_bridge #(
    .NUM_OPS(NUM_OPS), .NUM_RES(NUM_RES), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .UserCLK       (UserCLK),
    .resetn        (resetn),
    .ConfigBits    (ConfigBits),
    .cpu_op_data   (cpu_op_data),
    .cpu_op_valid  (cpu_op_valid),
    .cpu_op_ready  (cpu_op_ready),
    .fab_op_data   (fab_op_data),
    .fab_op_valid  (fab_op_valid),
    .fab_op_ack    (fab_op_ack),
    .fab_res_data  (fab_res_data),
    .fab_res_strobe(fab_res_strobe),
    .cpu_res_data  (cpu_res_data),
    .cpu_res_valid (cpu_res_valid),
    .cpu_res_ready (cpu_res_ready),
    .op_level      (op_level),
    .res_level     (res_level),
    .err_ovf       (err_ovf),
    .err_unf       (err_unf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [OW-1:0] op_q[$];
  logic [RW-1:0] res_q[$];
  bit m_ready_en = 1'b0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    cpu_op_data    = '0;
    cpu_op_valid   = 1'b0;
    fab_op_ack     = 1'b0;
    fab_res_data   = '0;
    fab_res_strobe = 1'b0;
    cpu_res_ready  = 1'b0;
  endtask

  // Compare every output against what the model predicts for current inputs
  task automatic check_outputs(input string ctx);
    bit ob = ConfigBits[0];
    bit rb = ConfigBits[1];
    bit e_fov;
    bit e_crv;
    if (ob) begin
      check({ctx, ".fab_op_valid"}, 32'(fab_op_valid), 32'(cpu_op_valid));
      check({ctx, ".fab_op_data"},  32'(fab_op_data),  32'(cpu_op_data));
      check({ctx, ".cpu_op_ready"}, 32'(cpu_op_ready), 32'(m_ready_en & fab_op_ack));
      check({ctx, ".op_level"},     32'(op_level),     32'(0));
    end else begin
      e_fov = (op_q.size() != 0);
      check({ctx, ".fab_op_valid"}, 32'(fab_op_valid), 32'(e_fov));
      if (e_fov) check({ctx, ".fab_op_data"}, 32'(fab_op_data), 32'(op_q[0]));
      check({ctx, ".cpu_op_ready"}, 32'(cpu_op_ready),
            32'(m_ready_en && op_q.size() != DEPTH));
      check({ctx, ".op_level"},     32'(op_level),     32'(op_q.size()));
    end
    if (rb) begin
      check({ctx, ".cpu_res_valid"}, 32'(cpu_res_valid), 32'(fab_res_strobe));
      check({ctx, ".cpu_res_data"},  32'(cpu_res_data),  32'(fab_res_data));
      check({ctx, ".res_level"},     32'(res_level),     32'(0));
    end else begin
      e_crv = (res_q.size() != 0);
      check({ctx, ".cpu_res_valid"}, 32'(cpu_res_valid), 32'(e_crv));
      if (e_crv) check({ctx, ".cpu_res_data"}, 32'(cpu_res_data), 32'(res_q[0]));
      check({ctx, ".res_level"},     32'(res_level),     32'(res_q.size()));
    end
    check({ctx, ".err_ovf"}, 32'(err_ovf), 32'(FLAGS_ON & m_ovf));
    check({ctx, ".err_unf"}, 32'(err_unf), 32'(FLAGS_ON & m_unf));
  endtask

  // One clock: check at the falling edge, then advance the model at the rising edge
  task automatic tick(input string ctx);
    bit ob, rb, op_push, op_pop, res_push, res_pop, ovf_ev, unf_ev;
    logic [OW-1:0] od;
    logic [RW-1:0] rd;
    @(negedge UserCLK);
    check_outputs(ctx);
    ob       = ConfigBits[0];
    rb       = ConfigBits[1];
    od       = cpu_op_data;
    rd       = fab_res_data;
    op_pop   = !ob && fab_op_ack && op_q.size() > 0;
    op_push  = !ob && cpu_op_valid && m_ready_en && op_q.size() < DEPTH;
    unf_ev   = !ob && fab_op_ack && op_q.size() == 0;
    res_pop  = !rb && cpu_res_ready && res_q.size() > 0;
    res_push = !rb && fab_res_strobe && (res_q.size() < DEPTH || res_pop);
    ovf_ev   = !rb && fab_res_strobe && !res_push;
    @(posedge UserCLK);
    if (op_pop)  void'(op_q.pop_front());
    if (op_push) op_q.push_back(od);
    if (res_pop)  void'(res_q.pop_front());
    if (res_push) res_q.push_back(rd);
    if (ovf_ev) m_ovf = 1'b1;
    if (unf_ev) m_unf = 1'b1;
    m_ready_en = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    op_q.delete();
    res_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_ready_en = 1'b0;
    #1;
    check("rst.fab_op_valid", 32'(fab_op_valid), 32'(0));
    check("rst.cpu_res_valid", 32'(cpu_res_valid), 32'(0));
    check("rst.levels", 32'({op_level, res_level}), 32'(0));
    repeat (2) @(posedge UserCLK);
    @(negedge UserCLK);
    check("rst.cpu_op_ready", 32'(cpu_op_ready), 32'(0));
    check("rst.err", 32'({err_ovf, err_unf}), 32'(0));
    resetn = 1'b1;
    #1;
    check("rst.ready_before_edge", 32'(cpu_op_ready), 32'(0));
    @(posedge UserCLK);
    m_ready_en = 1'b1;
    #1;
    check("rst.ready_after_edge", 32'(cpu_op_ready), 32'(1));
  endtask

  initial begin
    logic [OW-1:0] op_vals [3];
    logic [RW-1:0] res_exp [4];

    ConfigBits = 2'b00;
    idle();
    resetn = 1'b1;
    #2;
    do_reset();

    // Operand stream: three writes, then three acks
    op_vals[0] = 8'h12; op_vals[1] = 8'h34; op_vals[2] = 8'h56;
    for (int i = 0; i < 3; i++) begin
      cpu_op_valid = 1'b1;
      cpu_op_data  = op_vals[i];
      tick("opstream.wr");
    end
    idle();
    check("opstream.level", 32'(op_level), 32'(3));
    for (int i = 0; i < 3; i++) begin
      check("opstream.head", 32'(fab_op_data), 32'(op_vals[i]));
      fab_op_ack = 1'b1;
      tick("opstream.ack");
    end
    idle();
    check("opstream.valid_low", 32'(fab_op_valid), 32'(0));

    // Operand full, then a refused 5th write with a simultaneous ack
    for (int i = 0; i < 4; i++) begin
      cpu_op_valid = 1'b1;
      cpu_op_data  = 8'hA0 + 8'(i);
      tick("opfull.wr");
    end
    idle();
    check("opfull.ready", 32'(cpu_op_ready), 32'(0));
    cpu_op_valid = 1'b1;
    cpu_op_data  = 8'hEE;
    fab_op_ack   = 1'b1;
    tick("opfull.wr_ack");
    idle();
    check("opfull.level", 32'(op_level), 32'(3));
    for (int i = 1; i < 4; i++) begin
      check("opfull.head", 32'(fab_op_data), 32'(8'hA0 + 8'(i)));
      fab_op_ack = 1'b1;
      tick("opfull.drain");
    end
    idle();
    check("opfull.empty", 32'(fab_op_valid), 32'(0));

    // Result full with a write-through on pop
    for (int i = 0; i < 4; i++) begin
      fab_res_strobe = 1'b1;
      fab_res_data   = 12'h111 * 12'(i + 1);
      tick("resfull.strobe");
    end
    fab_res_strobe = 1'b1;
    fab_res_data   = 12'hABC;
    cpu_res_ready  = 1'b1;
    tick("resfull.wt");
    idle();
    check("resfull.level", 32'(res_level), 32'(4));
    res_exp[0] = 12'h222; res_exp[1] = 12'h333; res_exp[2] = 12'h444; res_exp[3] = 12'hABC;
    for (int i = 0; i < 4; i++) begin
      check("resfull.head", 32'(cpu_res_data), 32'(res_exp[i]));
      cpu_res_ready = 1'b1;
      tick("resfull.drain");
    end
    idle();

    // Result overflow: 5 strobes, no pop
    for (int i = 0; i < 5; i++) begin
      fab_res_strobe = 1'b1;
      fab_res_data   = 12'h501 + 12'(i);
      tick("resovf.strobe");
    end
    idle();
    check("resovf.level", 32'(res_level), 32'(4));
    check("resovf.err_ovf", 32'(err_ovf), 32'(FLAGS_ON));
    for (int i = 0; i < 4; i++) begin
      check("resovf.head", 32'(cpu_res_data), 32'(12'h501 + 12'(i)));
      cpu_res_ready = 1'b1;
      tick("resovf.drain");
    end
    idle();
    check("resovf.empty", 32'(cpu_res_valid), 32'(0));

    // Operand underflow: ack with an empty FIFO changes nothing
    fab_op_ack = 1'b1;
    tick("unf.ack");
    idle();
    check("unf.err_unf", 32'(err_unf), 32'(FLAGS_ON));
    check("unf.level", 32'(op_level), 32'(0));

    // Bypass: one held entry in each FIFO must survive the bypass window
    cpu_op_valid = 1'b1; cpu_op_data = 8'h77;
    fab_res_strobe = 1'b1; fab_res_data = 12'h777;
    tick("byp.prefill");
    idle();
    ConfigBits     = 2'b11;
    cpu_op_data    = 8'hF0;
    cpu_op_valid   = 1'b1;
    fab_op_ack     = 1'b1;
    fab_res_strobe = 1'b1;
    fab_res_data   = 12'h9C7;
    cpu_res_ready  = 1'b1;
    #1;
    check("byp.fab_op_data", 32'(fab_op_data), 32'(8'hF0));
    check("byp.cpu_res_valid", 32'(cpu_res_valid), 32'(1));
    check("byp.cpu_res_data", 32'(cpu_res_data), 32'(12'h9C7));
    check("byp.levels", 32'({op_level, res_level}), 32'(0));
    tick("byp.cycle");
    fab_res_strobe = 1'b0;
    #1;
    check("byp.strobe_low", 32'(cpu_res_valid), 32'(0));
    tick("byp.cycle2");
    idle();
    ConfigBits = 2'b00;
    #1;
    check("byp.op_held", 32'(fab_op_data), 32'(8'h77));
    check("byp.res_held", 32'(cpu_res_data), 32'(12'h777));
    fab_op_ack = 1'b1; cpu_res_ready = 1'b1;
    tick("byp.drain");
    idle();

    // Reset mid-operation with two entries in each FIFO
    for (int i = 0; i < 2; i++) begin
      cpu_op_valid = 1'b1; cpu_op_data = 8'hC0 + 8'(i);
      fab_res_strobe = 1'b1; fab_res_data = 12'hD00 + 12'(i);
      tick("midrst.fill");
    end
    idle();
    check("midrst.pre_levels", 32'({op_level, res_level}), 32'({3'd2, 3'd2}));
    @(negedge UserCLK);
    #2;
    do_reset();
    cpu_op_valid = 1'b1; cpu_op_data = 8'h3C;
    tick("midrst.wr");
    idle();
    check("midrst.head", 32'(fab_op_data), 32'(8'h3C));
    check("midrst.level", 32'(op_level), 32'(1));
    fab_op_ack = 1'b1;
    tick("midrst.drain");
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      cpu_op_valid   = ($urandom_range(0, 99) < 55);
      cpu_op_data    = OW'($urandom);
      fab_op_ack     = ($urandom_range(0, 99) < 45);
      fab_res_strobe = ($urandom_range(0, 99) < 50);
      fab_res_data   = RW'($urandom);
      cpu_res_ready  = ($urandom_range(0, 99) < 40);
      tick("rand");
    end
    idle();
    tick("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
